transmit_buffer: RTL and testbench

TRANSMIT_BUFFER -- requirements
Module: transmit_buffer

---
 rtl/transmit_buffer.sv | 127 ++++++++++++
 tb/tb_transmit_buffer.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/transmit_buffer.sv
// Block-to-byte transmit buffer: a DEPTH-deep FIFO of 128-bit blocks feeding a
// serializer that hands one byte at a time to a UART transmitter, MSB byte first.
module transmit_buffer #(
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [127:0] block_in,
    input  logic         write_en,
    input  logic         tx_done,
    output logic [7:0]   tx_data,
    output logic         tx_start,
    output logic         empty,
    output logic         full,
    output logic         of,
    output logic         busy,
    output logic         block_done
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_START,
        S_WAIT
    } state_t;

    state_t         state, state_nx;
    logic [127:0]   mem [DEPTH];
    logic [AW-1:0]  wr_ptr, rd_ptr;
    logic [CW-1:0]  count;
    logic [127:0]   shift_reg;
    logic [3:0]     byte_idx;
    logic           push, pop;
    logic           last_ack;

    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));

    // full is sampled before this cycle's pop, so a write during LOAD with a full FIFO is dropped.
    assign push     = write_en && !full;
    assign pop      = (state == S_LOAD);
    assign last_ack = (state == S_WAIT) && tx_done && (byte_idx == 4'd15);

    assign busy       = (state != S_IDLE);
    assign tx_start   = (state == S_START);
    assign block_done = last_ack && !reset;

    // NOTE: the storage array has no reset; the pointers and count alone define its valid contents.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= block_in;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            of     <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (write_en && full) begin
                of <= 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // NOTE: next state is defaulted before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (!empty) state_nx = S_LOAD;
            S_LOAD:  state_nx = S_START;
            S_START: state_nx = S_WAIT;
            S_WAIT: begin
                if (tx_done) begin
                    state_nx = (byte_idx == 4'd15) ? S_IDLE : S_START;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // tx_data is loaded on entry to START so the byte is already valid while tx_start is high,
    // and it then holds until the following START.
    always_ff @(posedge clk) begin
        if (reset) begin
            shift_reg <= '0;
            byte_idx  <= '0;
            tx_data   <= 8'h00;
        end else begin
            if (state == S_LOAD) begin
                shift_reg <= mem[rd_ptr];
                byte_idx  <= '0;
                tx_data   <= mem[rd_ptr][127:120];
            end else if ((state == S_WAIT) && tx_done && (byte_idx != 4'd15)) begin
                shift_reg <= shift_reg << 8;
                byte_idx  <= byte_idx + 4'd1;
                tx_data   <= shift_reg[119:112];
            end
        end
    end

endmodule

// File: tb/tb_transmit_buffer.sv
// Directed bench for transmit_buffer: stimulus pushes expected bytes into a queue,
// an independent monitor pops and compares them on every tx_start.
module tb_transmit_buffer;

    logic         clk = 1'b0;
    logic         reset;
    logic [127:0] block_in;
    logic         write_en;
    logic         tx_done;
    logic [7:0]   tx_data;
    logic         tx_start;
    logic         empty;
    logic         full;
    logic         of;
    logic         busy;
    logic         block_done;

    transmit_buffer #(.DEPTH(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .block_in   (block_in),
        .write_en   (write_en),
        .tx_done    (tx_done),
        .tx_data    (tx_data),
        .tx_start   (tx_start),
        .empty      (empty),
        .full       (full),
        .of         (of),
        .busy       (busy),
        .block_done (block_done)
    );

    always #5 clk = ~clk;

    localparam logic [127:0] BLK_A = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    localparam logic [127:0] BLK_B = 128'hDEADBEEF_01234567_89ABCDEF_F0E1D2C3;
    localparam logic [127:0] BLK_C = 128'hA5A5A5A5_5A5A5A5A_C3C3C3C3_3C3C3C3C;
    localparam logic [127:0] BLK_D = 128'h0F1E2D3C_4B5A6978_8796A5B4_C3D2E1F0;

    int         n_tests = 0;
    int         n_fails = 0;
    logic [7:0] exp_q[$];
    int         total_bytes = 0;
    int         bytes_in_block = 0;
    int         done_cnt = 0;
    bit         stray_mode = 1'b0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_block(input logic [127:0] b);
        for (int i = 15; i >= 0; i--) begin
            exp_q.push_back(b[i*8 +: 8]);
        end
    endtask

    // Called at a negedge; holds write_en for one rising edge, returns at the next negedge.
    task automatic write_blk(input logic [127:0] b, input bit accepted);
        write_en = 1'b1;
        block_in = b;
        if (accepted) push_block(b);
        @(negedge clk);
        write_en = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int cyc = 0;
        while (!(empty && !busy && exp_q.size() == 0) && cyc < 1500) begin
            @(negedge clk);
            cyc++;
        end
        check(name, cyc < 1500, 1'b1);
        repeat (3) @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        exp_q.delete();
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // UART model: acknowledges each byte 4 cycles after tx_start; optionally injects stray tx_done.
    initial begin
        int timer = 0;
        tx_done = 1'b0;
        forever begin
            @(negedge clk);
            tx_done = 1'b0;
            if (reset) begin
                timer = 0;
            end else begin
                if (timer > 0) begin
                    timer--;
                    if (timer == 0) tx_done = 1'b1;
                end
                if (tx_start) begin
                    timer = 4;
                    if (stray_mode) tx_done = 1'b1;
                end
                if (stray_mode && !busy) tx_done = 1'b1;
            end
        end
    end

    // Monitor / scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                bytes_in_block = 0;
            end else begin
                if (tx_start) begin
                    total_bytes++;
                    bytes_in_block++;
                    if (exp_q.size() == 0) begin
                        n_tests++;
                        n_fails++;
                        $display("FAIL unexpected_tx_start: got tx_data %0h with no byte expected", tx_data);
                    end else begin
                        check("tx_data", tx_data, exp_q.pop_front());
                    end
                end
                if (block_done) begin
                    done_cnt++;
                    check("bytes_per_block", bytes_in_block, 16);
                    bytes_in_block = 0;
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int d0;
        int t0;
        int cyc;
        reset    = 1'b1;
        write_en = 1'b0;
        block_in = '0;
        repeat (3) @(negedge clk);
        check("rst_tx_start", tx_start, 1'b0);
        check("rst_block_done", block_done, 1'b0);
        check("rst_tx_data", tx_data, 8'h00);
        check("rst_empty", empty, 1'b1);
        check("rst_full", full, 1'b0);
        check("rst_of", of, 1'b0);
        check("rst_busy", busy, 1'b0);
        reset = 1'b0;
        @(negedge clk);

        // Single block with start latency.
        d0 = done_cnt;
        write_blk(BLK_A, 1'b1);
        check("lat_idle_busy", busy, 1'b0);
        check("lat_idle_empty", empty, 1'b0);
        @(negedge clk);
        check("lat_load_busy", busy, 1'b1);
        check("lat_load_start", tx_start, 1'b0);
        @(negedge clk);
        check("lat_start", tx_start, 1'b1);
        wait_idle("single_drain");
        check("single_done_cnt", done_cnt - d0, 1);
        check("single_empty", empty, 1'b1);
        check("single_busy", busy, 1'b0);

        // Two back-to-back blocks fill DEPTH=2.
        d0 = done_cnt;
        write_blk(BLK_A, 1'b1);
        write_blk(BLK_B, 1'b1);
        check("b2b_full", full, 1'b1);
        wait_idle("b2b_drain");
        check("b2b_done_cnt", done_cnt - d0, 2);
        check("b2b_of", of, 1'b0);

        // Third write lands in the LOAD cycle while full: dropped, overflow sticks.
        d0 = done_cnt;
        write_blk(BLK_A, 1'b1);
        write_blk(BLK_B, 1'b1);
        write_blk(BLK_C, 1'b0);
        check("ovf_of", of, 1'b1);
        wait_idle("ovf_drain");
        check("ovf_done_cnt", done_cnt - d0, 2);
        check("ovf_of_sticky", of, 1'b1);
        do_reset();
        check("ovf_of_cleared", of, 1'b0);

        // Write during LOAD with FIFO not full: accepted, count unchanged.
        d0 = done_cnt;
        write_blk(BLK_C, 1'b1);
        @(negedge clk);
        check("loadwr_busy", busy, 1'b1);
        write_blk(BLK_D, 1'b1);
        check("loadwr_empty", empty, 1'b0);
        check("loadwr_full", full, 1'b0);
        check("loadwr_start", tx_start, 1'b1);
        wait_idle("loadwr_drain");
        check("loadwr_done_cnt", done_cnt - d0, 2);
        check("loadwr_of", of, 1'b0);

        // Stray tx_done in IDLE and START.
        stray_mode = 1'b1;
        repeat (5) @(negedge clk);
        check("stray_idle_busy", busy, 1'b0);
        check("stray_idle_start", tx_start, 1'b0);
        d0 = done_cnt;
        write_blk(BLK_D, 1'b1);
        wait_idle("stray_drain");
        check("stray_done_cnt", done_cnt - d0, 1);
        stray_mode = 1'b0;
        repeat (2) @(negedge clk);

        // Reset after the 5th byte with one block queued; reset dominates write_en.
        d0 = done_cnt;
        t0 = total_bytes;
        write_blk(BLK_A, 1'b1);
        write_blk(BLK_B, 1'b1);
        cyc = 0;
        while (total_bytes < t0 + 5 && cyc < 500) begin
            @(negedge clk);
            cyc++;
        end
        check("midrst_reached_5", cyc < 500, 1'b1);
        @(negedge clk);
        reset    = 1'b1;
        write_en = 1'b1;
        block_in = BLK_C;
        exp_q.delete();
        @(negedge clk);
        write_en = 1'b0;
        check("midrst_tx_start", tx_start, 1'b0);
        check("midrst_block_done", block_done, 1'b0);
        check("midrst_tx_data", tx_data, 8'h00);
        check("midrst_empty", empty, 1'b1);
        check("midrst_full", full, 1'b0);
        check("midrst_busy", busy, 1'b0);
        check("midrst_of", of, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        t0 = total_bytes;
        repeat (120) @(negedge clk);
        check("midrst_no_tx", total_bytes - t0, 0);
        check("midrst_no_done", done_cnt - d0, 0);
        check("midrst_still_empty", empty, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fails);
        $finish;
    end

endmodule
